mux_nx1_switch_blank: RTL and testbench

MUX_NX1_SWITCH_BLANK -- requirements
Module: mux_nx1_switch_blank

---
 rtl/pt_feedback_pkg.sv | 11 +
 rtl/blank_counter.sv | 47 ++++
 rtl/mux_nx1_switch_blank.sv | 150 +++++++++++++++
 tb/tb_mux_nx1_switch_blank.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pt_feedback_pkg.sv
// Shared state encoding for the blanking channel switch.
// Pure type definitions; no logic, no latency.
// Nothing here applies backpressure.
package pt_feedback;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

endpackage

// File: rtl/blank_counter.sv
// Loadable down-counter that tracks how many samples still have to be blanked.
// Latency: count changes on the edge after load_i/dec_i; zero_o reflects the register.
// No backpressure; load_i wins over dec_i, and a decrement at zero is ignored.
//
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load load_val_i into the counter
//   load_val_i    : value to load
//   dec_i         : decrement by one (ignored when load_i is high or the count is zero)
//   cnt_o         : current count
//   zero_o        : count is zero
module blank_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_nx1_switch_blank.sv
// N:1 sample mux that suppresses a programmable number of samples after every channel switch.
// Latency: 1 cycle from in_i/data_valid_i of the active channel to out_o/data_valid_o.
// No backpressure: samples arriving while blanking are consumed and discarded, never stalled.
//
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   sel_i          : requested channel (out-of-range codes select channel 0)
//   blank_len_i    : samples to suppress after a switch, captured on the switch edge
//   data_valid_i   : per-channel sample strobe, bit c = channel c
//   in_i           : flattened samples, channel c at [c*WIDTH +: WIDTH]
//   data_valid_o   : registered output strobe
//   out_o          : registered output sample (holds when nothing is forwarded)
//   blanking_o     : high while blanking
//   switch_done_o  : one-cycle pulse when a switch completes
module mux_nx1_switch_blank
  import pt_feedback::*;
#(
  parameter int  WIDTH     = 16,
  parameter int  N_CH      = 4,
  parameter int  CNT_W     = 8,
  parameter int  HOLD_MODE = 0,
  localparam int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [CNT_W-1:0]      blank_len_i,
  input  logic [N_CH-1:0]       data_valid_i,
  input  logic [N_CH*WIDTH-1:0] in_i,
  output logic                  data_valid_o,
  output logic [WIDTH-1:0]      out_o,
  output logic                  blanking_o,
  output logic                  switch_done_o
);

  state_e           state_q,       state_d;
  logic [SEL_W-1:0] act_q,         act_d;
  logic             data_valid_q,  data_valid_d;
  logic [WIDTH-1:0] out_q,         out_d;
  logic             switch_done_q, switch_done_d;

  logic [SEL_W-1:0] eff_sel;
  logic             act_vld;
  logic [WIDTH-1:0] act_dat;
  logic             switch_det;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_last;

  // Out-of-range requests fall back to channel 0.
  always_comb begin
    eff_sel = '0;
    if (32'(sel_i) < N_CH) begin
      eff_sel = sel_i;
    end
  end

  // Inline channel mux on the active channel; other channels' strobes never reach the FSM.
  always_comb begin
    act_vld = 1'b0;
    act_dat = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (act_q == SEL_W'(c)) begin
        act_vld = data_valid_i[c];
        act_dat = in_i[c*WIDTH +: WIDTH];
      end
    end
  end

  assign switch_det = (eff_sel != act_q);
  assign cnt_last   = (cnt == CNT_W'(1));

  always_comb begin
    state_d       = state_q;
    act_d         = act_q;
    data_valid_d  = 1'b0;
    out_d         = out_q;
    switch_done_d = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;

    if (switch_det) begin
      // A switch always wins, including over a pending last-sample edge in BLANK,
      // so an abandoned switch never reports completion.
      act_d    = eff_sel;
      cnt_load = 1'b1;
      if (blank_len_i == '0) begin
        state_d       = ST_RUN;
        switch_done_d = 1'b1;
      end else begin
        state_d = ST_BLANK;
      end
    end else if (state_q == ST_RUN) begin
      data_valid_d = act_vld;
      if (act_vld) begin
        out_d = act_dat;
      end
    end else begin
      if (act_vld) begin
        // Consumed sample: data is discarded, only the strobe may be echoed.
        cnt_dec      = 1'b1;
        data_valid_d = (HOLD_MODE != 0);
        if (cnt_last) begin
          state_d       = ST_RUN;
          switch_done_d = 1'b1;
        end
      end else if (cnt_zero) begin
        // Unreachable in normal operation (BLANK is only entered with a nonzero
        // count); recover quietly rather than blank forever.
        state_d = ST_RUN;
      end
    end
  end

  blank_counter #(
    .CNT_W (CNT_W)
  ) u_blank_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (blank_len_i),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_RUN;
      act_q         <= '0;
      data_valid_q  <= 1'b0;
      out_q         <= '0;
      switch_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      data_valid_q  <= data_valid_d;
      out_q         <= out_d;
      switch_done_q <= switch_done_d;
    end
  end

  assign data_valid_o  = data_valid_q;
  assign out_o         = out_q;
  assign blanking_o    = (state_q == ST_BLANK);
  assign switch_done_o = switch_done_q;

endmodule

// File: tb/tb_mux_nx1_switch_blank.sv
// Directed vector bench for mux_nx1_switch_blank.
// Two 4-channel instances (HOLD_MODE 0 and 1) share stimulus; a 3-channel
// instance gives the 2-bit select an out-of-range code to exercise the fallback.
module tb_mux_nx1_switch_blank;

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  blen;
    logic [3:0]  vm;
    logic [7:0]  n;
    logic        ev0;
    logic        ev1;
    logic [15:0] eo;
    logic        eb;
    logic        ed;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic [7:0]  blen;
  logic [3:0]  dv;
  logic [63:0] in_v;

  logic        vld_h0, blk_h0, done_h0;
  logic [15:0] out_h0;
  logic        vld_h1, blk_h1, done_h1;
  logic [15:0] out_h1;
  logic        vld_c3, blk_c3, done_c3;
  logic [15:0] out_c3;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mux_nx1_switch_blank #(.WIDTH(16), .N_CH(4), .CNT_W(8), .HOLD_MODE(0)) dut_h0 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .blank_len_i(blen),
    .data_valid_i(dv), .in_i(in_v),
    .data_valid_o(vld_h0), .out_o(out_h0), .blanking_o(blk_h0), .switch_done_o(done_h0)
  );

  mux_nx1_switch_blank #(.WIDTH(16), .N_CH(4), .CNT_W(8), .HOLD_MODE(1)) dut_h1 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .blank_len_i(blen),
    .data_valid_i(dv), .in_i(in_v),
    .data_valid_o(vld_h1), .out_o(out_h1), .blanking_o(blk_h1), .switch_done_o(done_h1)
  );

  mux_nx1_switch_blank #(.WIDTH(16), .N_CH(3), .CNT_W(8), .HOLD_MODE(0)) dut_c3 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .blank_len_i(blen),
    .data_valid_i(dv[2:0]), .in_i(in_v[47:0]),
    .data_valid_o(vld_c3), .out_o(out_c3), .blanking_o(blk_c3), .switch_done_o(done_c3)
  );

  function automatic vec_t mkv(input logic [1:0] s, input logic [7:0] bl, input logic [3:0] m,
                               input logic [7:0] n, input logic v0, input logic v1,
                               input logic [15:0] o, input logic b, input logic d);
    vec_t v;
    v.sel = s; v.blen = bl; v.vm = m; v.n = n;
    v.ev0 = v0; v.ev1 = v1; v.eo = o; v.eb = b; v.ed = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Channel c carries c*0x1000 + n.
  task automatic drive(input logic [1:0] s, input logic [7:0] bl, input logic [3:0] m,
                       input logic [7:0] n);
    sel  = s;
    blen = bl;
    dv   = m;
    for (int c = 0; c < 4; c++) begin
      in_v[c*16 +: 16] = 16'(c * 4096) + {8'h00, n};
    end
  endtask

  task automatic run_row(input vec_t v, input int idx);
    drive(v.sel, v.blen, v.vm, v.n);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("r%0d vld_h0", idx), {31'd0, vld_h0}, {31'd0, v.ev0});
    chk($sformatf("r%0d vld_h1", idx), {31'd0, vld_h1}, {31'd0, v.ev1});
    chk($sformatf("r%0d out_h0", idx), {16'd0, out_h0}, {16'd0, v.eo});
    chk($sformatf("r%0d out_h1", idx), {16'd0, out_h1}, {16'd0, v.eo});
    chk($sformatf("r%0d blank_h0", idx), {31'd0, blk_h0}, {31'd0, v.eb});
    chk($sformatf("r%0d blank_h1", idx), {31'd0, blk_h1}, {31'd0, v.eb});
    chk($sformatf("r%0d done_h0", idx), {31'd0, done_h0}, {31'd0, v.ed});
    chk($sformatf("r%0d done_h1", idx), {31'd0, done_h1}, {31'd0, v.ed});
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, " out_h0"},  {16'd0, out_h0}, 32'd0);
    chk({tag, " vld_h0"},  {31'd0, vld_h0}, 32'd0);
    chk({tag, " blk_h0"},  {31'd0, blk_h0}, 32'd0);
    chk({tag, " done_h0"}, {31'd0, done_h0}, 32'd0);
    chk({tag, " out_h1"},  {16'd0, out_h1}, 32'd0);
    chk({tag, " vld_h1"},  {31'd0, vld_h1}, 32'd0);
    chk({tag, " blk_h1"},  {31'd0, blk_h1}, 32'd0);
    chk({tag, " out_c3"},  {16'd0, out_c3}, 32'd0);
  endtask

  initial begin
    vec_t tbl[$];

    // Steady state on channel 0.
    tbl.push_back(mkv(0, 3, 4'hF,  0, 1, 1, 16'h0000, 0, 0));
    tbl.push_back(mkv(0, 3, 4'h0,  0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mkv(0, 3, 4'hF,  1, 1, 1, 16'h0001, 0, 0));
    tbl.push_back(mkv(0, 3, 4'h0,  0, 0, 0, 16'h0001, 0, 0));
    tbl.push_back(mkv(0, 3, 4'hF,  2, 1, 1, 16'h0002, 0, 0));
    tbl.push_back(mkv(0, 3, 4'h0,  0, 0, 0, 16'h0002, 0, 0));
    // Switch to ch2, blank 3; blank_len change mid-blank must be ignored.
    tbl.push_back(mkv(2, 3, 4'h0,  0, 0, 0, 16'h0002, 1, 0));
    tbl.push_back(mkv(2, 7, 4'hF,  3, 0, 1, 16'h0002, 1, 0));
    tbl.push_back(mkv(2, 7, 4'h0,  0, 0, 0, 16'h0002, 1, 0));
    tbl.push_back(mkv(2, 7, 4'hF,  4, 0, 1, 16'h0002, 1, 0));
    tbl.push_back(mkv(2, 7, 4'h0,  0, 0, 0, 16'h0002, 1, 0));
    tbl.push_back(mkv(2, 7, 4'hF,  5, 0, 1, 16'h0002, 0, 1));
    tbl.push_back(mkv(2, 7, 4'h0,  0, 0, 0, 16'h0002, 0, 0));
    tbl.push_back(mkv(2, 7, 4'hF,  6, 1, 1, 16'h2006, 0, 0));
    tbl.push_back(mkv(2, 7, 4'h0,  0, 0, 0, 16'h2006, 0, 0));
    // Zero-length switch back to ch0: done on the switch edge, sample on that edge dropped.
    tbl.push_back(mkv(0, 0, 4'hF,  7, 0, 0, 16'h2006, 0, 1));
    tbl.push_back(mkv(0, 0, 4'h0,  0, 0, 0, 16'h2006, 0, 0));
    tbl.push_back(mkv(0, 0, 4'hF,  8, 1, 1, 16'h0008, 0, 0));
    tbl.push_back(mkv(0, 0, 4'h0,  0, 0, 0, 16'h0008, 0, 0));
    // Switch to ch2 (blank 5), redirect to ch1 after 2 consumed samples.
    tbl.push_back(mkv(2, 5, 4'h0,  0, 0, 0, 16'h0008, 1, 0));
    tbl.push_back(mkv(2, 5, 4'hF,  9, 0, 1, 16'h0008, 1, 0));
    tbl.push_back(mkv(2, 5, 4'h0,  0, 0, 0, 16'h0008, 1, 0));
    tbl.push_back(mkv(2, 5, 4'hF, 10, 0, 1, 16'h0008, 1, 0));
    tbl.push_back(mkv(1, 5, 4'h0,  0, 0, 0, 16'h0008, 1, 0));
    tbl.push_back(mkv(1, 5, 4'hF, 11, 0, 1, 16'h0008, 1, 0));
    tbl.push_back(mkv(1, 5, 4'h0,  0, 0, 0, 16'h0008, 1, 0));
    tbl.push_back(mkv(1, 5, 4'hF, 12, 0, 1, 16'h0008, 1, 0));
    tbl.push_back(mkv(1, 5, 4'h0,  0, 0, 0, 16'h0008, 1, 0));
    tbl.push_back(mkv(1, 5, 4'hF, 13, 0, 1, 16'h0008, 1, 0));
    tbl.push_back(mkv(1, 5, 4'h0,  0, 0, 0, 16'h0008, 1, 0));
    tbl.push_back(mkv(1, 5, 4'hF, 14, 0, 1, 16'h0008, 1, 0));
    tbl.push_back(mkv(1, 5, 4'h0,  0, 0, 0, 16'h0008, 1, 0));
    tbl.push_back(mkv(1, 5, 4'hF, 15, 0, 1, 16'h0008, 0, 1));
    tbl.push_back(mkv(1, 5, 4'h0,  0, 0, 0, 16'h0008, 0, 0));
    tbl.push_back(mkv(1, 5, 4'hF, 16, 1, 1, 16'h1010, 0, 0));
    // Switch on the same edge the counter would reach zero: switch wins, no done.
    tbl.push_back(mkv(3, 1, 4'h0,  0, 0, 0, 16'h1010, 1, 0));
    tbl.push_back(mkv(0, 2, 4'hF, 17, 0, 0, 16'h1010, 1, 0));
    tbl.push_back(mkv(0, 2, 4'h0,  0, 0, 0, 16'h1010, 1, 0));
    tbl.push_back(mkv(0, 2, 4'hF, 18, 0, 1, 16'h1010, 1, 0));
    tbl.push_back(mkv(0, 2, 4'h0,  0, 0, 0, 16'h1010, 1, 0));
    tbl.push_back(mkv(0, 2, 4'hF, 19, 0, 1, 16'h1010, 0, 1));
    tbl.push_back(mkv(0, 2, 4'h0,  0, 0, 0, 16'h1010, 0, 0));
    tbl.push_back(mkv(0, 2, 4'hF, 20, 1, 1, 16'h0014, 0, 0));
    // Strobes on inactive channels only, then on the active one only.
    tbl.push_back(mkv(0, 2, 4'hE, 21, 0, 0, 16'h0014, 0, 0));
    tbl.push_back(mkv(0, 2, 4'h1, 22, 1, 1, 16'h0016, 0, 0));

    rst_n = 1'b0;
    drive(0, 3, 4'h0, 0);
    #3;
    rst_chk("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_row(tbl[i], i);
    end

    // Reset mid-BLANK: outputs clear at once, the abandoned switch never completes.
    run_row(mkv(2, 4, 4'h0,  0, 0, 0, 16'h0016, 1, 0), 100);
    run_row(mkv(2, 4, 4'hF, 23, 0, 1, 16'h0016, 1, 0), 101);
    #2 rst_n = 1'b0;
    #1;
    rst_chk("midblank_rst");
    @(negedge clk);
    drive(0, 4, 4'h0, 0);
    rst_n = 1'b1;
    run_row(mkv(0, 4, 4'h0,  0, 0, 0, 16'h0000, 0, 0), 102);
    run_row(mkv(0, 4, 4'hF, 24, 1, 1, 16'h0018, 0, 0), 103);

    // Nonzero selection on the first edge after reset is a switch.
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_row(mkv(2, 0, 4'hF, 25, 0, 0, 16'h0000, 0, 1), 104);
    run_row(mkv(2, 0, 4'h0,  0, 0, 0, 16'h0000, 0, 0), 105);
    run_row(mkv(2, 0, 4'hF, 26, 1, 1, 16'h201A, 0, 0), 106);

    // Out-of-range code on the 3-channel instance falls back to channel 0.
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(3, 0, 4'hF, 27);
    @(posedge clk);
    @(negedge clk);
    chk("oor vld_c3",  {31'd0, vld_c3},  32'd1);
    chk("oor out_c3",  {16'd0, out_c3},  32'h001B);
    chk("oor blk_c3",  {31'd0, blk_c3},  32'd0);
    chk("oor done_c3", {31'd0, done_c3}, 32'd0);
    chk("oor done_h0", {31'd0, done_h0}, 32'd1);
    drive(3, 0, 4'h0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("oor idle vld_c3", {31'd0, vld_c3}, 32'd0);
    chk("oor idle out_c3", {16'd0, out_c3}, 32'h001B);
    drive(3, 0, 4'hF, 28);
    @(posedge clk);
    @(negedge clk);
    chk("oor2 out_c3", {16'd0, out_c3}, 32'h001C);
    chk("oor2 vld_c3", {31'd0, vld_c3}, 32'd1);
    chk("oor2 out_h0", {16'd0, out_h0}, 32'h301C);
    chk("oor2 vld_h0", {31'd0, vld_h0}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
